// File: rtl/membus_pkg.sv
// membus_pkg: shared types and constants for the memory-bus arbiter.
//   state_e : sequencer states (idle, core data cycle, DMA data cycle)
//   req_e   : requester identity remembered for round-robin tie breaking
//   BE_*    : RAM byte-enable patterns
package membus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CPU_D = 2'd1,
        ST_DMA_D = 2'd2
    } state_e;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DMA = 1'b1
    } req_e;

    localparam logic [1:0] BE_WORD = 2'b11;
    localparam logic [1:0] BE_LO   = 2'b01;
    localparam logic [1:0] BE_HI   = 2'b10;

endpackage

// File: rtl/membus_lane.sv
// membus_lane: combinational byte-lane steering for one requester.
//   word_i   : 1 = word access, 0 = byte access
//   addr0_i  : byte address bit 0 (selects the lane of a byte access)
//   wdata_i  : requester write data (byte writes use [7:0])
//   rdata_i  : raw RAM read data
//   be_o     : RAM byte enables
//   wdata_o  : RAM write data, byte replicated to both lanes for byte writes
//   rdata_o  : read data to the requester, byte reads zero-extended
module membus_lane
    import membus_pkg::*;
(
    input  logic        word_i,
    input  logic        addr0_i,
    input  logic [15:0] wdata_i,
    input  logic [15:0] rdata_i,
    output logic [1:0]  be_o,
    output logic [15:0] wdata_o,
    output logic [15:0] rdata_o
);

    always_comb begin
        if (word_i) begin
            be_o    = BE_WORD;
            wdata_o = wdata_i;
            rdata_o = rdata_i;
        end else begin
            be_o    = addr0_i ? BE_HI : BE_LO;
            wdata_o = {wdata_i[7:0], wdata_i[7:0]};
            rdata_o = {8'h00, (addr0_i ? rdata_i[15:8] : rdata_i[7:0])};
        end
    end

endmodule

// File: rtl/membus_arb.sv
// membus_arb: shares one synchronous 16-bit RAM between the core and a DMA
// requester. Converts the core's address/data two-cycle bus into RAM strobes,
// steers byte lanes, and stalls the core via CPU_CLKEN while DMA owns the RAM.
//   CLOCK, RESET           : clock, synchronous active-low reset
//   CPU_MREAD/MWRITE/MWORD : core request (address cycle) and access size
//   CPU_MD / CPU_MQ        : core address+write data in / read data out
//   CPU_CLKEN              : core clock enable (low = core stalled)
//   DMA_*                  : DMA request, grant/done pulses, data
//   MEM_*                  : RAM word address, strobes, byte enables, data
module membus_arb
    import membus_pkg::*;
(
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        CPU_MREAD,
    input  logic        CPU_MWRITE,
    input  logic        CPU_MWORD,
    input  logic [15:0] CPU_MD,
    output logic [15:0] CPU_MQ,
    output logic        CPU_CLKEN,
    input  logic        DMA_REQ,
    input  logic        DMA_WRITE,
    input  logic        DMA_WORD,
    input  logic [15:0] DMA_ADDR,
    input  logic [15:0] DMA_WDATA,
    output logic        DMA_GNT,
    output logic        DMA_DONE,
    output logic [15:0] DMA_RDATA,
    output logic [14:0] MEM_ADDR,
    output logic        MEM_RE,
    output logic        MEM_WE,
    output logic [1:0]  MEM_BE,
    output logic [15:0] MEM_WDATA,
    input  logic [15:0] MEM_RDATA
);

    state_e      state_q, state_d;
    req_e        last_q, last_d;
    logic [15:0] addr_q, addr_d;
    logic        word_q, word_d;
    logic        write_q, write_d;

    logic        cpu_req, cpu_win, dma_win, in_idle, in_cpu_d;
    logic        core_word, core_a0;
    logic [1:0]  core_be, dma_be;
    logic [15:0] core_wdata, core_rdata, dma_wdata, dma_rdata;

    assign cpu_req  = CPU_MREAD | CPU_MWRITE;
    assign in_idle  = (state_q == ST_IDLE);
    assign in_cpu_d = (state_q == ST_CPU_D);

    // Round-robin: on a tie the requester not served last wins.
    assign cpu_win = in_idle & cpu_req & (~DMA_REQ | (last_q == REQ_DMA));
    assign dma_win = in_idle & DMA_REQ & (~cpu_req | (last_q == REQ_CPU));

    // In the data cycle CPU_MD carries write data, so size and lane come
    // from the address latched in the address cycle.
    assign core_word = in_cpu_d ? word_q  : CPU_MWORD;
    assign core_a0   = in_cpu_d ? addr_q[0] : CPU_MD[0];

    membus_lane u_lane_cpu (
        .word_i  (core_word),
        .addr0_i (core_a0),
        .wdata_i (CPU_MD),
        .rdata_i (MEM_RDATA),
        .be_o    (core_be),
        .wdata_o (core_wdata),
        .rdata_o (core_rdata)
    );

    membus_lane u_lane_dma (
        .word_i  (DMA_WORD),
        .addr0_i (DMA_ADDR[0]),
        .wdata_i (DMA_WDATA),
        .rdata_i (MEM_RDATA),
        .be_o    (dma_be),
        .wdata_o (dma_wdata),
        .rdata_o (dma_rdata)
    );

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            state_q <= ST_IDLE;
            last_q  <= REQ_DMA;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Core request attributes are data only; they are consumed solely in
    // ST_CPU_D, which is always entered from a cycle that loads them.
    always_ff @(posedge CLOCK) begin
        addr_q  <= addr_d;
        word_q  <= word_d;
        write_q <= write_d;
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        addr_d    = addr_q;
        word_d    = word_q;
        write_d   = write_q;
        CPU_MQ    = 16'h0000;
        CPU_CLKEN = 1'b1;
        DMA_GNT   = 1'b0;
        DMA_DONE  = 1'b0;
        DMA_RDATA = 16'h0000;
        MEM_ADDR  = 15'h0000;
        MEM_RE    = 1'b0;
        MEM_WE    = 1'b0;
        MEM_BE    = 2'b00;
        MEM_WDATA = 16'h0000;

        case (state_q)
            ST_IDLE: begin
                if (cpu_win) begin
                    addr_d  = CPU_MD;
                    word_d  = CPU_MWORD;
                    write_d = CPU_MWRITE;
                    if (CPU_MREAD) begin
                        MEM_RE   = 1'b1;
                        MEM_ADDR = CPU_MD[15:1];
                        MEM_BE   = core_be;
                    end
                    state_d = ST_CPU_D;
                    last_d  = REQ_CPU;
                end else if (dma_win) begin
                    DMA_GNT   = 1'b1;
                    CPU_CLKEN = ~cpu_req;
                    if (!DMA_WRITE) begin
                        MEM_RE   = 1'b1;
                        MEM_ADDR = DMA_ADDR[15:1];
                        MEM_BE   = dma_be;
                    end
                    state_d = ST_DMA_D;
                    last_d  = REQ_DMA;
                end
            end
            ST_CPU_D: begin
                if (write_q) begin
                    MEM_WE    = 1'b1;
                    MEM_ADDR  = addr_q[15:1];
                    MEM_BE    = core_be;
                    MEM_WDATA = core_wdata;
                end else begin
                    CPU_MQ = core_rdata;
                end
                state_d = ST_IDLE;
            end
            ST_DMA_D: begin
                if (DMA_WRITE) begin
                    MEM_WE    = 1'b1;
                    MEM_ADDR  = DMA_ADDR[15:1];
                    MEM_BE    = dma_be;
                    MEM_WDATA = dma_wdata;
                end else begin
                    DMA_RDATA = dma_rdata;
                end
                DMA_DONE  = 1'b1;
                CPU_CLKEN = ~cpu_req;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule
